// File: rtl/sp_usb_dram_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : sp_bridge_pkg                                                |
// | Description : Shared constants and FSM state encoding for the USB-DRAM     |
// |               line bridge.                                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package sp_bridge_pkg;

  localparam int LINE_BYTES = 16;
  localparam int ADDR_BYTES = 4;

  localparam logic [7:0] DEF_OP_WRITE = 8'h57;
  localparam logic [7:0] DEF_OP_READ  = 8'h52;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h4B;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_ADDR  = 3'd1;
  localparam logic [STATE_W-1:0] S_WDATA = 3'd2;
  localparam logic [STATE_W-1:0] S_WCMD  = 3'd3;
  localparam logic [STATE_W-1:0] S_ACK   = 3'd4;
  localparam logic [STATE_W-1:0] S_RCMD  = 3'd5;
  localparam logic [STATE_W-1:0] S_RWAIT = 3'd6;
  localparam logic [STATE_W-1:0] S_RSEND = 3'd7;

endpackage
`default_nettype wire

// File: rtl/sp_usb_dram_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sp_usb_dram_bridge                                           |
// | Description : Decodes host write/read packets from the USB byte FIFO into  |
// |               single 128-bit DRAM line commands and returns ack/line data. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sp_usb_dram_bridge
  import sp_bridge_pkg::*;
#(
  parameter logic [7:0] OP_WRITE = DEF_OP_WRITE,
  parameter logic [7:0] OP_READ  = DEF_OP_READ,
  parameter logic [7:0] ACK_BYTE = DEF_ACK_BYTE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         usb_avail,
  input  logic [7:0]   usb_rx,
  output logic         usb_read,
  input  logic         usb_full,
  output logic [7:0]   usb_tx,
  output logic         usb_write,
  input  logic         dram_ready,
  output logic [24:0]  dram_addr,
  output logic [127:0] dram_din,
  output logic [15:0]  dram_mask,
  output logic         dram_we,
  output logic         dram_re,
  input  logic [127:0] dram_dout
);

  localparam logic [3:0] C_ADDR_LAST = 4'(ADDR_BYTES - 1);
  localparam logic [3:0] C_LINE_LAST = 4'(LINE_BYTES - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic [3:0]         r_cnt;
  logic               r_is_write;
  logic               r_rd_hold;
  logic               r_wr_hold;
  logic [31:0]        r_addr;
  logic [127:0]       r_wline;
  logic [127:0]       r_rline;
  logic               w_rx_state;
  logic               w_tx_state;
  logic               w_unused;

  // Upper address byte bits are accepted on the wire but carry no meaning.
  assign w_unused  = ^r_addr[31:25];
  assign dram_addr = r_addr[24:0];
  assign dram_din  = r_wline;
  assign dram_mask = 16'hFFFF;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (usb_read && (usb_rx == OP_WRITE || usb_rx == OP_READ)) begin
          w_state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (usb_read && r_cnt == C_ADDR_LAST) begin
          w_state_next = r_is_write ? S_WDATA : S_RCMD;
        end
      end
      S_WDATA: begin
        if (usb_read && r_cnt == C_LINE_LAST) w_state_next = S_WCMD;
      end
      S_WCMD:  if (dram_ready) w_state_next = S_ACK;
      S_ACK:   if (usb_write)  w_state_next = S_IDLE;
      S_RCMD:  if (dram_ready) w_state_next = S_RWAIT;
      S_RWAIT: if (dram_ready) w_state_next = S_RSEND;
      S_RSEND: begin
        if (usb_write && r_cnt == C_LINE_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: the hold flags stop a second pulse while the FIFO flags lag.
  always_comb begin
    w_rx_state = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
    w_tx_state = (r_state == S_ACK) || (r_state == S_RSEND);
    usb_read   = w_rx_state && usb_avail && !r_rd_hold;
    usb_write  = w_tx_state && !usb_full && !r_wr_hold;
    usb_tx     = 8'h00;
    if (r_state == S_ACK) begin
      usb_tx = ACK_BYTE;
    end else if (r_state == S_RSEND) begin
      usb_tx = r_rline[{r_cnt, 3'b000} +: 8];
    end
    dram_we = (r_state == S_WCMD) && dram_ready;
    dram_re = (r_state == S_RCMD) && dram_ready;
  end

  // Datapath; rd_hold resets high so no read can fire while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_is_write <= 1'b0;
      r_rd_hold  <= 1'b1;
      r_wr_hold  <= 1'b0;
      r_addr     <= 32'd0;
      r_wline    <= 128'd0;
      r_rline    <= 128'd0;
    end else begin
      r_rd_hold <= usb_read;
      r_wr_hold <= usb_write;

      if (w_state_next != r_state) begin
        r_cnt <= 4'd0;
      end else if (r_state != S_IDLE && (usb_read || usb_write)) begin
        r_cnt <= r_cnt + 4'd1;
      end

      if (usb_read) begin
        unique case (r_state)
          S_IDLE:  r_is_write <= (usb_rx == OP_WRITE);
          S_ADDR:  r_addr[{r_cnt[1:0], 3'b000} +: 8] <= usb_rx;
          S_WDATA: r_wline[{r_cnt, 3'b000} +: 8] <= usb_rx;
          default: ;
        endcase
      end

      if (r_state == S_RWAIT && dram_ready) begin
        r_rline <= dram_dout;
      end
    end
  end

endmodule
`default_nettype wire
